// File: rtl/c_reg_fd_pkg.sv
// Shared constants and helpers for the c_reg_fd register family.
// Holds the sync-mode encodings and the binary-string decoder.
package c_reg_fd_pkg;

    // Sync priority encodings (C_SYNC_PRIORITY)
    localparam int c_set   = 0;
    localparam int c_clear = 1;

    // Sync gating encodings (C_SYNC_ENABLE)
    localparam int c_override    = 0;
    localparam int c_no_override = 1;

    // Longest init string accepted, in characters; also the widest register.
    localparam int C_MAX_CHARS = 256;
    localparam int C_STR_BITS  = 8 * C_MAX_CHARS;

    // True when every character is '0', '1' or NUL padding.
    function automatic logic str_is_bin(input logic [C_STR_BITS-1:0] s);
        logic       ok;
        logic [7:0] ch;
        ok = 1'b1;
        for (int i = 0; i < C_MAX_CHARS; i++) begin
            ch = s[8*i +: 8];
            if (ch != 8'h00 && ch != "0" && ch != "1") begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Last character is bit 0; missing upper characters read as 0.
    function automatic logic [C_MAX_CHARS-1:0] str_to_bv(
        input logic [C_STR_BITS-1:0] s
    );
        logic [C_MAX_CHARS-1:0] bv;
        bv = '0;
        for (int i = 0; i < C_MAX_CHARS; i++) begin
            bv[i] = (s[8*i +: 8] == "1");
        end
        return bv;
    endfunction

endpackage

// File: rtl/c_reg_fd.sv
// Parameterised D register with clock enable and optional
// asynchronous and synchronous clear/set/init controls.
module c_reg_fd
    import c_reg_fd_pkg::*;
#(
    parameter     C_AINIT_VAL     = "0",
    parameter int C_ENABLE_RLOCS  = 0,
    parameter int C_HAS_ACLR      = 0,
    parameter int C_HAS_AINIT     = 0,
    parameter int C_HAS_ASET      = 0,
    parameter int C_HAS_CE        = 0,
    parameter int C_HAS_SCLR      = 0,
    parameter int C_HAS_SINIT     = 0,
    parameter int C_HAS_SSET      = 0,
    parameter     C_SINIT_VAL     = "0",
    parameter int C_SYNC_ENABLE   = c_override,
    parameter int C_SYNC_PRIORITY = c_clear,
    parameter int C_WIDTH         = 16
) (
    input  logic               CLK,
    input  logic               ACLR,
    input  logic               ASET,
    input  logic               AINIT,
    input  logic               CE,
    input  logic               SCLR,
    input  logic               SSET,
    input  logic               SINIT,
    input  logic [C_WIDTH-1:0] D,
    output logic [C_WIDTH-1:0] Q
);

    // Init strings widened to the decoder's fixed input size.
    localparam logic [C_STR_BITS-1:0] AINIT_STR = C_STR_BITS'(C_AINIT_VAL);
    localparam logic [C_STR_BITS-1:0] SINIT_STR = C_STR_BITS'(C_SINIT_VAL);

    localparam logic [C_MAX_CHARS-1:0] AINIT_ALL = str_to_bv(AINIT_STR);
    localparam logic [C_MAX_CHARS-1:0] SINIT_ALL = str_to_bv(SINIT_STR);

    localparam logic [C_WIDTH-1:0] AINIT_V = AINIT_ALL[C_WIDTH-1:0];
    localparam logic [C_WIDTH-1:0] SINIT_V = SINIT_ALL[C_WIDTH-1:0];

    localparam logic [C_WIDTH-1:0] ALL_ONES = {C_WIDTH{1'b1}};
    localparam logic [C_WIDTH-1:0] ALL_ZERO = {C_WIDTH{1'b0}};

    localparam logic PRI_CLR  = (C_SYNC_PRIORITY == c_clear);
    localparam logic GATE_CE  = (C_SYNC_ENABLE == c_no_override);

    // Bad configurations stop elaboration rather than build garbage.
    if (C_WIDTH < 1 || C_WIDTH > C_MAX_CHARS) begin : g_bad_width
        $fatal(1, "c_reg_fd: C_WIDTH out of range");
    end
    if ($bits(C_AINIT_VAL) > C_STR_BITS) begin : g_long_ainit
        $fatal(1, "c_reg_fd: C_AINIT_VAL too long");
    end
    if ($bits(C_SINIT_VAL) > C_STR_BITS) begin : g_long_sinit
        $fatal(1, "c_reg_fd: C_SINIT_VAL too long");
    end
    if (!str_is_bin(AINIT_STR)) begin : g_bad_ainit
        $fatal(1, "c_reg_fd: C_AINIT_VAL not a binary string");
    end
    if (!str_is_bin(SINIT_STR)) begin : g_bad_sinit
        $fatal(1, "c_reg_fd: C_SINIT_VAL not a binary string");
    end
    if (C_ENABLE_RLOCS < 0 || C_ENABLE_RLOCS > 1) begin : g_bad_rloc
        $fatal(1, "c_reg_fd: C_ENABLE_RLOCS must be 0 or 1");
    end
    if (C_SYNC_ENABLE != c_override &&
        C_SYNC_ENABLE != c_no_override) begin : g_bad_sen
        $fatal(1, "c_reg_fd: C_SYNC_ENABLE must be 0 or 1");
    end
    if (C_SYNC_PRIORITY != c_set &&
        C_SYNC_PRIORITY != c_clear) begin : g_bad_spri
        $fatal(1, "c_reg_fd: C_SYNC_PRIORITY must be 0 or 1");
    end

    // Unused controls are tied inactive; an absent CE reads as 1.
    logic aclr_i;
    logic aset_i;
    logic ainit_i;
    logic ce_i;
    logic sclr_i;
    logic sset_i;
    logic sinit_i;

    assign aclr_i  = (C_HAS_ACLR  != 0) ? ACLR  : 1'b0;
    assign aset_i  = (C_HAS_ASET  != 0) ? ASET  : 1'b0;
    assign ainit_i = (C_HAS_AINIT != 0) ? AINIT : 1'b0;
    assign ce_i    = (C_HAS_CE    != 0) ? CE    : 1'b1;
    assign sclr_i  = (C_HAS_SCLR  != 0) ? SCLR  : 1'b0;
    assign sset_i  = (C_HAS_SSET  != 0) ? SSET  : 1'b0;
    assign sinit_i = (C_HAS_SINIT != 0) ? SINIT : 1'b0;

    // In no_override mode the sync controls only act on enabled edges.
    logic sync_gate;
    logic sclr_e;
    logic sset_e;
    logic sinit_e;

    assign sync_gate = GATE_CE ? ce_i : 1'b1;
    assign sclr_e    = sclr_i  & sync_gate;
    assign sset_e    = sset_i  & sync_gate;
    assign sinit_e   = sinit_i & sync_gate;

    // Select alt over cur. Written as an xor-mask so an unknown select
    // only pollutes bits where the two candidates actually differ.
    function automatic logic [C_WIDTH-1:0] take(
        input logic [C_WIDTH-1:0] cur,
        input logic [C_WIDTH-1:0] alt,
        input logic               sel
    );
        return cur ^ ((cur ^ alt) & {C_WIDTH{sel}});
    endfunction

    logic [C_WIDTH-1:0] q_d;
    logic [C_WIDTH-1:0] q_q = AINIT_V;

    // Next value: later stages override earlier ones, so the highest
    // priority sync control is applied last.
    always_comb begin
        logic [C_WIDTH-1:0] v;
        q_d = q_q;
        v   = take(q_q, D, ce_i);
        v   = take(v, SINIT_V, sinit_e);
        if (PRI_CLR) begin
            v = take(v, ALL_ONES, sset_e);
            v = take(v, ALL_ZERO, sclr_e);
        end else begin
            v = take(v, ALL_ZERO, sclr_e);
            v = take(v, ALL_ONES, sset_e);
        end
        q_d = v;
    end

    // Storage with async clear > set > init; forced value holds until
    // the first clock edge after release.
    always_ff @(posedge CLK or posedge aclr_i or
                posedge aset_i or posedge ainit_i) begin
        if (aclr_i) begin
            q_q <= ALL_ZERO;
        end else if (aset_i) begin
            q_q <= ALL_ONES;
        end else if (ainit_i) begin
            q_q <= AINIT_V;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: tb/tb_c_reg_fd.sv
// Scoreboard bench for c_reg_fd: four instances share one stimulus
// stream and are checked against a rule-level model.
module tb_c_reg_fd;

    logic       CLK;
    logic       ACLR;
    logic       ASET;
    logic       AINIT;
    logic       CE;
    logic       SCLR;
    logic       SSET;
    logic       SINIT;
    logic [3:0] D;
    logic [3:0] q0;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [0:0] q3;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       ce;
        logic       sclr;
        logic       sset;
        logic       sinit;
        logic       aclr;
        logic       aset;
        logic       ainit;
        logic [3:0] d;
    } in_t;

    typedef struct packed {
        logic       aclr;
        logic       aset;
        logic       ainit;
        logic       ce;
        logic       sclr;
        logic       sset;
        logic       sinit;
        logic       sync_en;
        logic       pri_clr;
        logic [3:0] ainit_v;
        logic [3:0] sinit_v;
        logic [3:0] mask;
    } cfg_t;

    typedef struct {
        int         k;
        logic [3:0] v;
    } aexp_t;

    logic [3:0] exp_q [4][$];
    aexp_t      aq [$];
    logic [3:0] mq [4];
    event       async_ev;

    // u0: all sync controls, override, clear wins
    c_reg_fd #(
        .C_WIDTH(4), .C_HAS_CE(1), .C_HAS_SCLR(1), .C_HAS_SSET(1),
        .C_HAS_SINIT(1), .C_SINIT_VAL("1001"),
        .C_SYNC_ENABLE(0), .C_SYNC_PRIORITY(1)
    ) u0 (
        .CLK(CLK), .ACLR(ACLR), .ASET(ASET), .AINIT(AINIT), .CE(CE),
        .SCLR(SCLR), .SSET(SSET), .SINIT(SINIT), .D(D), .Q(q0)
    );

    // u1: all sync controls, no_override, set wins
    c_reg_fd #(
        .C_WIDTH(4), .C_HAS_CE(1), .C_HAS_SCLR(1), .C_HAS_SSET(1),
        .C_HAS_SINIT(1), .C_SINIT_VAL("1001"),
        .C_SYNC_ENABLE(1), .C_SYNC_PRIORITY(0)
    ) u1 (
        .CLK(CLK), .ACLR(ACLR), .ASET(ASET), .AINIT(AINIT), .CE(CE),
        .SCLR(SCLR), .SSET(SSET), .SINIT(SINIT), .D(D), .Q(q1)
    );

    // u2: all async controls plus CE and SCLR
    c_reg_fd #(
        .C_WIDTH(4), .C_HAS_ACLR(1), .C_HAS_ASET(1), .C_HAS_AINIT(1),
        .C_AINIT_VAL("0110"), .C_HAS_CE(1), .C_HAS_SCLR(1)
    ) u2 (
        .CLK(CLK), .ACLR(ACLR), .ASET(ASET), .AINIT(AINIT), .CE(CE),
        .SCLR(SCLR), .SSET(SSET), .SINIT(SINIT), .D(D), .Q(q2)
    );

    // u3: one bit, no optional ports
    c_reg_fd #(
        .C_WIDTH(1)
    ) u3 (
        .CLK(CLK), .ACLR(ACLR), .ASET(ASET), .AINIT(AINIT), .CE(CE),
        .SCLR(SCLR), .SSET(SSET), .SINIT(SINIT), .D(D[0:0]), .Q(q3)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic cfg_t cfg(input int k);
        cfg_t c;
        c = '0;
        c.mask = 4'hF;
        case (k)
            0: begin
                c.ce = 1; c.sclr = 1; c.sset = 1; c.sinit = 1;
                c.sync_en = 0; c.pri_clr = 1; c.sinit_v = 4'h9;
            end
            1: begin
                c.ce = 1; c.sclr = 1; c.sset = 1; c.sinit = 1;
                c.sync_en = 1; c.pri_clr = 0; c.sinit_v = 4'h9;
            end
            2: begin
                c.aclr = 1; c.aset = 1; c.ainit = 1; c.ainit_v = 4'h6;
                c.ce = 1; c.sclr = 1; c.pri_clr = 1;
            end
            default: c.mask = 4'h1;
        endcase
        return c;
    endfunction

    // Value Q must show after the next edge (async controls win outright).
    function automatic logic [3:0] nxt(input int k, input logic [3:0] q,
                                       input in_t x);
        cfg_t c;
        logic ce, sc, ss, si;
        logic [3:0] r;
        c = cfg(k);
        if (c.aclr && x.aclr) return 4'h0;
        if (c.aset && x.aset) return 4'hF & c.mask;
        if (c.ainit && x.ainit) return c.ainit_v;
        ce = c.ce ? x.ce : 1'b1;
        sc = c.sclr & x.sclr;
        ss = c.sset & x.sset;
        si = c.sinit & x.sinit;
        if (c.sync_en && !ce) begin
            sc = 0; ss = 0; si = 0;
        end
        if (sc && ss)  r = c.pri_clr ? 4'h0 : 4'hF;
        else if (sc)   r = 4'h0;
        else if (ss)   r = 4'hF;
        else if (si)   r = c.sinit_v;
        else if (ce)   r = x.d;
        else           r = q;
        return r & c.mask;
    endfunction

    function automatic logic [3:0] qv(input int k);
        case (k)
            0:       return q0;
            1:       return q1;
            2:       return q2;
            default: return {3'b000, q3};
        endcase
    endfunction

    task automatic check(input string nm, input int k,
                         input logic [3:0] exp);
        logic [3:0] got;
        got = qv(k);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s u%0d: Q=%h expected %h at %0t",
                     nm, k, got, exp, $time);
        end
    endtask

    // Apply inputs away from the edge and queue the post-edge values.
    task automatic drive(input in_t x);
        @(negedge CLK);
        CE = x.ce; SCLR = x.sclr; SSET = x.sset; SINIT = x.sinit;
        ACLR = x.aclr; ASET = x.aset; AINIT = x.ainit; D = x.d;
        for (int k = 0; k < 4; k++) begin
            mq[k] = nxt(k, mq[k], x);
            exp_q[k].push_back(mq[k]);
        end
    endtask

    // Queue an immediate check of the async instance.
    task automatic async_check();
        aexp_t a;
        a.k = 2;
        a.v = mq[2];
        aq.push_back(a);
        -> async_ev;
    endtask

    // Edge monitor
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge CLK);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (exp_q[k].size() > 0) begin
                    e = exp_q[k].pop_front();
                    check("edge", k, e);
                end
            end
        end
    end

    // Async / power-up monitor
    initial begin
        aexp_t a;
        forever begin
            @(async_ev);
            #1;
            while (aq.size() > 0) begin
                a = aq.pop_front();
                check("async", a.k, a.v);
            end
        end
    end

    initial begin
        in_t   x;
        aexp_t a;
        CE = 0; SCLR = 0; SSET = 0; SINIT = 0;
        ACLR = 0; ASET = 0; AINIT = 0; D = 4'h0;
        mq[0] = 4'h0; mq[1] = 4'h0; mq[2] = 4'h6; mq[3] = 4'h0;

        #1;
        for (int k = 0; k < 4; k++) begin
            a.k = k;
            a.v = mq[k];
            aq.push_back(a);
        end
        -> async_ev;

        // load with CE, then hold with CE low
        x = '0; x.ce = 1; x.d = 4'hA; drive(x);
        x = '0; x.ce = 0; x.d = 4'h5; drive(x);
        // SCLR and SSET together
        x = '0; x.ce = 1; x.sclr = 1; x.sset = 1; x.d = 4'h7; drive(x);
        // SINIT with CE low
        x = '0; x.sinit = 1; x.d = 4'h2; drive(x);
        // ASET mid-cycle, then ACLR with ASET
        x = '0; x.aset = 1; x.ce = 1; x.d = 4'h3; drive(x);
        async_check();
        x = '0; x.aclr = 1; x.aset = 1; x.ce = 1; x.d = 4'h3; drive(x);
        async_check();
        // release, then load
        x = '0; x.ce = 1; x.d = 4'h3; drive(x);
        // SCLR against held AINIT
        x = '0; x.ce = 1; x.sclr = 1; x.ainit = 1; x.d = 4'hC; drive(x);
        async_check();
        x = '0; x.ce = 1; x.sclr = 1; x.ainit = 1; x.d = 4'hD; drive(x);
        x = '0; x.ce = 1; x.d = 4'hE; drive(x);
        // one-bit toggle while unused controls wiggle
        for (int i = 0; i < 8; i++) begin
            x = '0;
            x.d = 4'(i & 1);
            x.aclr = i[1];
            x.sset = i[2];
            drive(x);
        end

        // random traffic
        for (int i = 0; i < 500; i++) begin
            x.d     = 4'($urandom);
            x.ce    = ($urandom_range(0, 3) != 0);
            x.sclr  = ($urandom_range(0, 5) == 0);
            x.sset  = ($urandom_range(0, 5) == 0);
            x.sinit = ($urandom_range(0, 5) == 0);
            x.aclr  = ($urandom_range(0, 11) == 0);
            x.aset  = ($urandom_range(0, 11) == 0);
            x.ainit = ($urandom_range(0, 11) == 0);
            drive(x);
        end

        x = '0; drive(x);
        repeat (3) @(posedge CLK);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
